pad_debounce: RTL

PAD_DEBOUNCE -- requirements
Module: pad_debounce

---
 rtl/pad_debounce_pkg.sv | 13 +
 rtl/pad_debounce_chan.sv | 61 ++++++
 rtl/pad_debounce.sv | 52 +++++
 3 files changed

// File: rtl/pad_debounce_pkg.sv
// Shared defaults and width helper for the pad/key debouncer.
// Imported by the top level and by the per-channel sub-module.
package pad_debounce_pkg;

    localparam int DEFAULT_TICK_DIV     = 50000;
    localparam int DEFAULT_STABLE_TICKS = 8;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pad_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, tick-driven stability counter,
// and registered press/release strobes.
module pad_debounce_chan
    import pad_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic debounced,
    output logic press,
    output logic release_strobe
);

    localparam int             CW       = width_of(STABLE_TICKS);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(STABLE_TICKS - 1);
    localparam logic           INACTIVE = (ACTIVE_LOW != 0);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          lvl;

    // Reset loads the released pad level so a key held idle across reset never strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= {2{INACTIVE}};
        end else begin
            sync_reg <= {sync_reg[0], raw};
        end
    end

    assign lvl = sync_reg[1] ^ INACTIVE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg        <= '0;
            debounced      <= 1'b0;
            press          <= 1'b0;
            release_strobe <= 1'b0;
        end else begin
            press          <= 1'b0;
            release_strobe <= 1'b0;
            if (tick) begin
                if (lvl == debounced) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_MAX) begin
                    cnt_reg        <= '0;
                    debounced      <= lvl;
                    press          <= lvl;
                    release_strobe <= ~lvl;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pad_debounce.sv
// Multi-channel pad/key debouncer: shared sample-tick prescaler feeding WIDTH
// independent channels. The release strobe is release_strobe (release is reserved).
module pad_debounce
    import pad_debounce_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_strobe
);

    localparam int            PW        = width_of(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_reg;
    logic          tick;

    assign tick = (presc_reg == PRESC_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        pad_debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .clk            (clk),
            .reset_n        (reset_n),
            .tick           (tick),
            .raw            (raw_in[gi]),
            .debounced      (debounced[gi]),
            .press          (press[gi]),
            .release_strobe (release_strobe[gi])
        );
    end

endmodule
